// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters and sync decode with frame-granular run/stop
// Ports: clk pixel clock; rstb async active-low reset; run frame request level;
//   h_c_en/h_c/v_c active enable and coordinates; hsync/vsync syncs;
//   frame_start first-pixel pulse; de_d/hsync_d/vsync_d one-clock delayed copies;
//   busy not-idle flag; frame_cnt completed frames (wraps)
module video_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP = 40,
  parameter int H_SYNC = 128,
  parameter int H_BP = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP = 1,
  parameter int V_SYNC = 4,
  parameter int V_BP = 23,
  parameter logic HS_POL = 1'b1,
  parameter logic VS_POL = 1'b1
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       run,
  output logic       h_c_en,
  output logic [9:0] h_c,
  output logic [9:0] v_c,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       de_d,
  output logic       hsync_d,
  output logic       vsync_d,
  output logic       busy,
  output logic [7:0] frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  state_t state, state_nx;
  logic [10:0] hcnt;
  logic [9:0] vcnt;
  logic h_last, v_last, eof, active;
  assign h_last = hcnt == 11'(H_TOTAL - 1);
  assign v_last = vcnt == 10'(V_TOTAL - 1);
  assign eof = h_last && v_last;
  assign active = state != IDLE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = run ? RUN : IDLE;
      RUN:      state_nx = run ? RUN : STOPPING;
      STOPPING: state_nx = run ? RUN : eof ? IDLE : STOPPING;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) state <= IDLE;
    else state <= state_nx;
  // Counters free-run outside IDLE; the last pixel wraps to 0,0 whether or
  // not the frame continues, so IDLE is always entered with cleared counters.
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!active) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= h_last ? 11'd0 : hcnt + 11'd1;
      if (h_last) vcnt <= v_last ? 10'd0 : vcnt + 10'd1;
    end
  // Outputs decode the current counters, so they lag the counters by a clock.
  // Counters sit at 0 in IDLE, which already decodes to inactive syncs and
  // zero coordinates; only the enable-like outputs need the state gate.
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      h_c_en <= 1'b0;
      h_c <= '0;
      v_c <= '0;
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
      frame_start <= 1'b0;
      de_d <= 1'b0;
      hsync_d <= ~HS_POL;
      vsync_d <= ~VS_POL;
      busy <= 1'b0;
      frame_cnt <= '0;
    end else begin
      h_c_en <= active && hcnt < 11'(H_ACTIVE) && vcnt < 10'(V_ACTIVE);
      h_c <= hcnt < 11'(H_ACTIVE) ? hcnt[9:0] : 10'd0;
      v_c <= vcnt < 10'(V_ACTIVE) ? vcnt : 10'd0;
      hsync <= (hcnt >= 11'(H_ACTIVE + H_FP) && hcnt < 11'(H_ACTIVE + H_FP + H_SYNC)) ? HS_POL : ~HS_POL;
      vsync <= (vcnt >= 10'(V_ACTIVE + V_FP) && vcnt < 10'(V_ACTIVE + V_FP + V_SYNC)) ? VS_POL : ~VS_POL;
      frame_start <= active && hcnt == 11'd0 && vcnt == 10'd0;
      de_d <= h_c_en;
      hsync_d <= hsync;
      vsync_d <= vsync;
      busy <= state_nx != IDLE;
      frame_cnt <= frame_cnt + {7'd0, active && eof};
    end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates the raster counters and sync timing that drive the pattern-generator layers (h_c, v_c, h_c_en) and the downstream video output.
- Default timing is 800x600 SVGA at a 40 MHz pixel clock.
- Also provides one-cycle-delayed sync/enable copies, aligned with the registered RGB output of the layers.
- Frame-granular run/stop control, so the display never sees a truncated frame.

Parameters:
- H_ACTIVE, 800, active pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BP, 23, vertical back porch (lines)
- HS_POL, 1, hsync active level (1 = active-high)
- VS_POL, 1, vsync active level (1 = active-high)

Ports:
- clk  in  1  pixel clock
- rstb  in  1  asynchronous active-low reset
- run  in  1  level request to generate frames
- h_c_en  out  1  active-pixel enable (both h and v in active region)
- h_c  out  10  active pixel column, 0..H_ACTIVE-1
- v_c  out  10  active line, 0..V_ACTIVE-1
- hsync  out  1  horizontal sync, aligned with h_c_en
- vsync  out  1  vertical sync, aligned with h_c_en
- frame_start  out  1  one-cycle pulse with the first active pixel of a frame
- de_d  out  1  h_c_en delayed one clock
- hsync_d  out  1  hsync delayed one clock
- vsync_d  out  1  vsync delayed one clock
- busy  out  1  high while state is not IDLE
- frame_cnt  out  8  completed-frame counter, wraps 255->0

Behaviour:
- Clock and reset: one clock, clk; reset rstb is asynchronous, active-low.
- Reset values: state IDLE; internal counters 0; h_c_en, h_c, v_c, frame_start, de_d, busy, frame_cnt = 0.
- Reset values, syncs: hsync, vsync, hsync_d, vsync_d at inactive level (~HS_POL, ~VS_POL).
- Counters: hcnt is 11 bits, 0..H_TOTAL-1, with H_TOTAL = sum of H params = 1056. vcnt is 10 bits, 0..V_TOTAL-1, with V_TOTAL = 628.
- Counter stepping: hcnt wraps to 0 after H_TOTAL-1. vcnt increments when hcnt wraps, and wraps to 0 after V_TOTAL-1.
- Line layout: active [0, H_ACTIVE-1], then FP, then SYNC, then BP. Frame layout is identical in lines.
- FSM IDLE:
  - Counters held at 0; outputs at reset values except frame_cnt, which holds.
  - run=1 sampled -> RUN. The next cycle has hcnt=vcnt=0.
- FSM RUN:
  - Counters advance every cycle.
  - run=0 sampled -> STOPPING; counters keep advancing.
- FSM STOPPING:
  - Counters keep advancing.
  - run=1 sampled -> RUN, with no timing disturbance.
  - At the last pixel of a frame (hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1) -> IDLE, and the counters return to 0.
- End of frame in RUN: wraps to 0,0 and continues.
- Output registration: all outputs are registered decodes of the current counters. The decode lags the counters by one clock, so first h_c_en=1 comes 2 clocks after run is first sampled high in IDLE.
- h_c_en = (hcnt<H_ACTIVE)&&(vcnt<V_ACTIVE).
- h_c = hcnt[9:0] while hcnt<H_ACTIVE, else 0.
- v_c = vcnt while vcnt<V_ACTIVE, else 0.
- hsync = HS_POL while H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL. Applies on every line, including vertical blanking.
- vsync = VS_POL while V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL. It changes only on the cycle vcnt changes (hcnt=0).
- frame_start = 1 for exactly the one cycle with hcnt=0 and vcnt=0 in RUN or STOPPING.
- frame_cnt increments on each frame completion (last pixel) in RUN or STOPPING.
- Delayed outputs: de_d, hsync_d, vsync_d equal h_c_en, hsync, vsync from the previous clock.
- busy = (state != IDLE), registered.
- Reset mid-frame: outputs go to reset values immediately. Restart requires run=1 after rstb deasserts.
- Counter widths are fixed: H_ACTIVE must be <= 1024 and V_TOTAL must be <= 1024. No runtime check.

Test Plan:
- Reset, then hold run=0 for 100 clocks -> all outputs at reset values; hsync/vsync = 0 (default polarity inactive); busy=0.
- run rises at cycle N -> busy=1 at N+1; h_c_en=1, h_c=0, v_c=0, frame_start=1 at N+2.
- Line timing:
  - h_c_en high for exactly 800 consecutive clocks, h_c stepping 0..799.
  - hsync high for 128 clocks, starting 840 clocks after h_c_en rises.
  - Line period 1056 clocks.
- Frame timing:
  - vsync high for 4 x 1056 clocks, starting at line 601.
  - Frame period 628 x 1056 clocks.
  - frame_start once per frame; frame_cnt +1 per frame.
- Drop run at v_c=300 -> the frame completes, busy=0 after the last pixel, frame_cnt +1.
- Re-raise run during STOPPING -> no gap and continuous frames.
- Reduced params (H 16/2/4/2, V 8/1/2/1) -> check the exact cycle positions of every output.
- Reset mid-frame, then run again -> restarts at 0,0.
- de_d/hsync_d/vsync_d equal one-clock-shifted copies throughout.
